// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus bit-serial shifts.
// Define SEQ_ALU_MUL_EN to turn opcode 1011 into a shift-add multiply (otherwise it is a halt/no-op).
module seq_alu #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [3:0]   OP,
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    output logic         Ready,
    output logic         Done,
    output logic [W-1:0] Out,
    output logic         OverflowOut
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_RST = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam logic [3:0] OP_LT  = 4'b1101;
    localparam logic [3:0] OP_EQL = 4'b1110;

    logic [1:0]    state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_q, out_d;
    logic          c_q, c_d;
`ifdef SEQ_ALU_MUL_EN
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W:0]    mac;
`endif

    logic [W:0]    add_res;
    logic [W:0]    sub_res;
    logic [CW-1:0] shamt;
    logic [W-1:0]  shift_nx;

    always_comb begin
        add_res  = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, c_q};
        sub_res  = {1'b0, InputA} + {1'b0, ~InputB} + {{W{1'b0}}, 1'b1} - {{W{1'b0}}, c_q};
        shamt    = (InputB >= W'(W)) ? CW'(W) : InputB[CW-1:0];
        shift_nx = (op_q == OP_SRL) ? (acc_q >> 1) : (acc_q << 1);
`ifdef SEQ_ALU_MUL_EN
        mac      = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        c_d     = c_q;
`ifdef SEQ_ALU_MUL_EN
        hi_d    = hi_q;
        mcand_d = mcand_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d    = OP;
                    state_d = DONE;
                    case (OP)
                        OP_ADD:  {c_d, out_d} = add_res;
                        OP_SUB:  {c_d, out_d} = sub_res;
                        4'b0010, 4'b0011, 4'b0100, 4'b1100: out_d = InputB;
                        4'b0101: out_d = InputA;
                        4'b0110: out_d = ~(InputA & InputB);
                        4'b0111: out_d = InputA | InputB;
                        4'b1111: out_d = ~InputB;
                        OP_RST: begin
                            out_d = '0;
                            c_d   = 1'b0;
                        end
                        OP_LT:   out_d = {{(W-1){1'b0}}, (InputA[W-1] | (InputA < InputB))};
                        OP_EQL:  out_d = {{(W-1){1'b0}}, (InputA == InputB)};
                        OP_SLL, OP_SRL: begin
                            if (shamt == '0) begin
                                out_d = InputA;
                            end else begin
                                acc_d   = InputA;
                                cnt_d   = shamt;
                                state_d = EXEC;
                            end
                        end
                        OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                            // Product accumulates in {hi, acc}; acc starts as the multiplier and drains LSB-first.
                            acc_d   = InputB;
                            hi_d    = '0;
                            mcand_d = InputA;
                            cnt_d   = CW'(W);
                            state_d = EXEC;
`else
                            out_d = '0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CW'(1);
`ifdef SEQ_ALU_MUL_EN
                if (op_q == OP_MUL) begin
                    {hi_d, acc_d} = {mac, acc_q[W-1:1]};
                end else begin
                    acc_d = shift_nx;
                end
`else
                acc_d = shift_nx;
`endif
                // Last step publishes straight from the next-state value so Out/C move only on the DONE edge.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    out_d   = acc_d;
`ifdef SEQ_ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        c_d = |hi_d;
                    end
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            c_q     <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            hi_q    <= '0;
            mcand_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            c_q     <= c_d;
`ifdef SEQ_ALU_MUL_EN
            hi_q    <= hi_d;
            mcand_q <= mcand_d;
`endif
        end
    end

    assign Ready       = (state_q == IDLE);
    assign Done        = (state_q == DONE);
    assign Out         = out_q;
    assign OverflowOut = c_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (W=8); expectations come from a behavioural model of each opcode.
module tb_seq_alu;

    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [3:0]   OP;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic         Ready;
    logic         Done;
    logic [W-1:0] Out;
    logic         OverflowOut;

    typedef struct {
        logic [7:0]  out;
        logic        c;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    logic c_model;
    int   n_vec;
    int   n_err;

    seq_alu #(.W(W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .OP          (OP),
        .InputA      (InputA),
        .InputB      (InputB),
        .Ready       (Ready),
        .Done        (Done),
        .Out         (Out),
        .OverflowOut (OverflowOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output exp_t e);
        int t;
        int s;
        e.out = 8'h00;
        e.c   = c_model;
        e.lat = 1;
        case (op)
            4'h0: begin t = int'(a) + int'(b) + int'(c_model); e.out = t[7:0]; e.c = t[8]; end
            4'h1: begin t = int'(a) + (255 - int'(b)) + 1 - int'(c_model); e.out = t[7:0]; e.c = t[8]; end
            4'h2, 4'h3, 4'h4, 4'hC: e.out = b;
            4'h5: e.out = a;
            4'h6: e.out = ~(a & b);
            4'h7: e.out = a | b;
            4'hF: e.out = ~b;
            4'hA: begin e.out = 8'h00; e.c = 1'b0; end
            4'hD: e.out = (a[7] || (a < b)) ? 8'h01 : 8'h00;
            4'hE: e.out = (a == b) ? 8'h01 : 8'h00;
            4'h8, 4'h9: begin
                s = (int'(b) > 8) ? 8 : int'(b);
                t = (op == 4'h8) ? (int'(a) << s) : (int'(a) >> s);
                e.out = t[7:0];
                e.lat = 32'(1 + s);
            end
            4'hB: begin
`ifdef SEQ_ALU_MUL_EN
                t = int'(a) * int'(b);
                e.out = t[7:0];
                e.c   = (t[15:8] != 8'h00);
                e.lat = 9;
`else
                e.out = 8'h00;
`endif
            end
            default: ;
        endcase
        c_model = e.c;
    endtask

    // hold=1 keeps Start asserted with scrambled operands until the result has been seen.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input bit hold);
        exp_t e;
        exp_t got_e;
        logic [7:0] prev_out;
        logic prev_c;
        int unsigned cyc;
        model(op, a, b, e);
        sb.push_back(e);
        prev_out = Out;
        prev_c   = OverflowOut;
        OP     = op;
        InputA = a;
        InputB = b;
        Start  = 1'b1;
        @(posedge Clk); #1;
        cyc = 1;
        if (!hold) Start = 1'b0;
        check_eq("ready_busy", 32'(Ready), 32'(0));
        while (!Done && cyc < 40) begin
            check_eq("ready_exec", 32'(Ready), 32'(0));
            check_eq("hold_exec", 32'({prev_c, prev_out}), 32'({OverflowOut, Out}));
            if (hold) begin
                OP     = 4'($urandom);
                InputA = 8'($urandom);
                InputB = 8'($urandom);
            end
            @(posedge Clk); #1;
            cyc++;
        end
        got_e = sb.pop_front();
        check_eq("done_seen", 32'(Done), 32'(1));
        check_eq("out", 32'(Out), 32'(got_e.out));
        check_eq("flag", 32'(OverflowOut), 32'(got_e.c));
        check_eq("latency", cyc, got_e.lat);
        @(posedge Clk); #1;
        if (hold) Start = 1'b0;
        check_eq("done_pulse", 32'(Done), 32'(0));
        check_eq("ready_idle", 32'(Ready), 32'(1));
        check_eq("out_held", 32'({OverflowOut, Out}), 32'({got_e.c, got_e.out}));
    endtask

    initial begin
        int unsigned dones;
        n_vec   = 0;
        n_err   = 0;
        c_model = 1'b0;
        Reset   = 1'b1;
        Start   = 1'b0;
        OP      = '0;
        InputA  = '0;
        InputB  = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check_eq("rst_ready", 32'(Ready), 32'(1));
        check_eq("rst_done", 32'(Done), 32'(0));
        check_eq("rst_out", 32'(Out), 32'(0));
        check_eq("rst_flag", 32'(OverflowOut), 32'(0));

        // Carry chain, shifts incl. B>=W, compare ops, flag clear.
        run_op(4'h0, 8'hFF, 8'h01, 0);
        run_op(4'h0, 8'h00, 8'h00, 0);
        run_op(4'h8, 8'h81, 8'd3, 0);
        run_op(4'h9, 8'h80, 8'd9, 0);
        run_op(4'h8, 8'h5A, 8'd0, 0);
        run_op(4'hD, 8'h80, 8'h01, 0);
        run_op(4'hE, 8'h5A, 8'h5A, 0);
        run_op(4'h0, 8'hFF, 8'hFF, 0);
        run_op(4'h1, 8'h05, 8'h03, 0);
        run_op(4'hA, 8'h12, 8'h34, 0);
        run_op(4'h1, 8'h03, 8'h05, 0);
        run_op(4'h0, 8'hFF, 8'h01, 0);
        run_op(4'hB, 8'h10, 8'h20, 0);
        run_op(4'hB, 8'h0F, 8'h0E, 0);

        for (int i = 0; i < 24; i++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom),
                   (i % 2 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom), 0);
        end

        run_op(4'h8, 8'h0B, 8'd5, 1);

        // Reset lands in the third EXEC cycle of a 6-bit shift; the op must vanish.
        run_op(4'h0, 8'hF0, 8'h20, 0);
        OP     = 4'h8;
        InputA = 8'h33;
        InputB = 8'd6;
        Start  = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check_eq("abort_exec", 32'(Ready), 32'(0));
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset   = 1'b0;
        c_model = 1'b0;
        check_eq("abort_ready", 32'(Ready), 32'(1));
        check_eq("abort_out", 32'(Out), 32'(0));
        check_eq("abort_flag", 32'(OverflowOut), 32'(0));
        check_eq("abort_done", 32'(Done), 32'(0));
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (Done) dones++;
        end
        check_eq("abort_no_done", dones, 32'(0));
        run_op(4'h0, 8'h01, 8'h02, 0);

        check_eq("sb_empty", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
